// File: rtl/display_pkg.sv
// Shared definitions for the display timing generator: config register
// addresses, default timing, the timing-set payload and the enable FSM states.
package display_pkg;

  // Storage width of one timing field; axis counter widths must not exceed it.
  localparam int unsigned TIMING_W = 16;

  typedef logic [TIMING_W-1:0] tfield_t;

  typedef struct packed {
    tfield_t sync;
    tfield_t back;
    tfield_t active;
    tfield_t total;
  } timing_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_t;

  localparam logic [2:0] CFG_H_SYNC   = 3'd0;
  localparam logic [2:0] CFG_H_BACK   = 3'd1;
  localparam logic [2:0] CFG_H_ACTIVE = 3'd2;
  localparam logic [2:0] CFG_H_TOTAL  = 3'd3;
  localparam logic [2:0] CFG_V_SYNC   = 3'd4;
  localparam logic [2:0] CFG_V_BACK   = 3'd5;
  localparam logic [2:0] CFG_V_ACTIVE = 3'd6;
  localparam logic [2:0] CFG_V_TOTAL  = 3'd7;

  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BACK   = 88;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_TOTAL  = 1056;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BACK   = 23;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_TOTAL  = 628;

endpackage

// File: rtl/display_timing_gen_timing_axis.sv
// One scan axis: position counter with wrap plus sync/blank/coordinate decode.
// All registered outputs are decoded from the next count so they line up with pos.
// Ports:
//   halt        force idle (pos 0, sync deasserted, blank, coord 0)
//   zero        restart at pos 0 with normal decode
//   step        advance pos, wrapping after total-1
//   total       live total used for the wrap decision
//   dec         timing set used to decode the next position
//   pos/sync/blank/coord  registered axis outputs
//   wrap_c      pos is the last count of the axis (combinational)
//   blank_nxt_c blank value being loaded this clock (combinational)
module timing_axis
  import display_pkg::*;
#(
  parameter int unsigned W        = 11,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         halt,
  input  logic         zero,
  input  logic         step,
  input  tfield_t      total,
  input  timing_t      dec,
  output logic [W-1:0] pos,
  output logic         sync,
  output logic         blank,
  output logic [W-1:0] coord,
  output logic         wrap_c,
  output logic         blank_nxt_c
);

  // Two guard bits so sync+back+active cannot overflow.
  localparam int unsigned SW = TIMING_W + 2;

  logic [W-1:0]  pos_nxt;
  logic [SW-1:0] p;
  logic [SW-1:0] act_lo;
  logic [SW-1:0] act_hi;
  logic          in_act;
  logic          in_sync;

  assign wrap_c = (TIMING_W'(pos) == (total - TIMING_W'(1)));

  // Next count.
  always_comb begin
    pos_nxt = pos;
    if (halt || zero) begin
      pos_nxt = '0;
    end else if (step) begin
      pos_nxt = wrap_c ? '0 : pos + W'(1);
    end
  end

  // Window decode of the next count; windows past total are simply never reached.
  always_comb begin
    p           = SW'(pos_nxt);
    act_lo      = SW'(dec.sync) + SW'(dec.back);
    act_hi      = act_lo + SW'(dec.active);
    in_act      = (p >= act_lo) && (p < act_hi) && (p < SW'(dec.total));
    in_sync     = (p < SW'(dec.sync)) && !halt;
    blank_nxt_c = halt || !in_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos   <= '0;
      sync  <= SYNC_POL;
      blank <= 1'b1;
      coord <= '0;
    end else begin
      pos   <= pos_nxt;
      sync  <= in_sync ? SYNC_POL : ~SYNC_POL;
      blank <= blank_nxt_c;
      coord <= (in_act && !halt) ? W'(p - act_lo) : '0;
    end
  end

endmodule

// File: rtl/display_timing_gen.sv
// Runtime-programmable raster timing generator.
// Ports:
//   clk, _reset             clock, synchronous active-low reset
//   enable                  run counters; low holds the generator idle
//   cfg_we/cfg_addr/cfg_data staging register writes (addr 0..3 H, 4..7 V)
//   cfg_pending             staged values await commit at frame wrap
//   h_pos/v_pos             raw scan counters
//   hsync/vsync             sync pins at the configured polarity
//   hblank/vblank/de        blanking and data enable
//   x/y                     active-area coordinates, 0 while blanked
//   line_start/frame_start  one-clock strobes when the counters reach 0
module display_timing_gen
  import display_pkg::*;
#(
  parameter int unsigned HCOUNT_WIDTH = 11,
  parameter int unsigned VCOUNT_WIDTH = 10,
  parameter int unsigned H_SYNC_DEF   = DEF_H_SYNC,
  parameter int unsigned H_BACK_DEF   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE_DEF = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL_DEF  = DEF_H_TOTAL,
  parameter int unsigned V_SYNC_DEF   = DEF_V_SYNC,
  parameter int unsigned V_BACK_DEF   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE_DEF = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL_DEF  = DEF_V_TOTAL,
  parameter bit          HSYNC_POL    = 1'b0,
  parameter bit          VSYNC_POL    = 1'b0
) (
  input  logic                    clk,
  input  logic                    _reset,
  input  logic                    enable,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [HCOUNT_WIDTH-1:0] cfg_data,
  output logic                    cfg_pending,
  output logic [HCOUNT_WIDTH-1:0] h_pos,
  output logic [VCOUNT_WIDTH-1:0] v_pos,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    de,
  output logic [HCOUNT_WIDTH-1:0] x,
  output logic [VCOUNT_WIDTH-1:0] y,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam timing_t H_DEF = '{sync:   TIMING_W'(H_SYNC_DEF),
                                back:   TIMING_W'(H_BACK_DEF),
                                active: TIMING_W'(H_ACTIVE_DEF),
                                total:  TIMING_W'(H_TOTAL_DEF)};
  localparam timing_t V_DEF = '{sync:   TIMING_W'(V_SYNC_DEF),
                                back:   TIMING_W'(V_BACK_DEF),
                                active: TIMING_W'(V_ACTIVE_DEF),
                                total:  TIMING_W'(V_TOTAL_DEF)};

  gen_state_t state, state_nxt;
  logic       halt_c, start_c, run_c;

  timing_t    h_live, v_live, h_stage, v_stage;
  timing_t    h_dec, v_dec;
  tfield_t    wr_val_c;
  logic       wr_ok_c, commit_c;
  logic       h_wrap_c, v_wrap_c;
  logic       h_blank_nxt_c, v_blank_nxt_c;

  // Enable FSM state register.
  always_ff @(posedge clk) begin
    if (!_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Enable FSM: IDLE restarts the raster at 0, RUN advances it.
  always_comb begin
    state_nxt = state;
    halt_c    = 1'b0;
    start_c   = 1'b0;
    run_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_RUN;
          start_c   = 1'b1;
        end else begin
          halt_c    = 1'b1;
        end
      end
      ST_RUN: begin
        if (enable) begin
          run_c     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          halt_c    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write qualification, commit detect, and decode-set select.
  // On the commit clock the next count is the first of the new frame, so it
  // is decoded with the staged set that becomes live at the same edge.
  always_comb begin
    wr_val_c = cfg_addr[2] ? TIMING_W'(cfg_data[VCOUNT_WIDTH-1:0])
                           : TIMING_W'(cfg_data);
    wr_ok_c  = cfg_we && !((cfg_addr[1:0] == 2'd3) && (wr_val_c < TIMING_W'(2)));
    commit_c = enable && cfg_pending && h_wrap_c && v_wrap_c;
    h_dec    = commit_c ? h_stage : h_live;
    v_dec    = commit_c ? v_stage : v_live;
  end

  // Staging/live registers; a write on the commit clock lands after the copy.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      h_live      <= H_DEF;
      v_live      <= V_DEF;
      h_stage     <= H_DEF;
      v_stage     <= V_DEF;
      cfg_pending <= 1'b0;
    end else begin
      if (commit_c) begin
        h_live <= h_stage;
        v_live <= v_stage;
      end
      if (wr_ok_c) begin
        case (cfg_addr)
          CFG_H_SYNC:   h_stage.sync   <= wr_val_c;
          CFG_H_BACK:   h_stage.back   <= wr_val_c;
          CFG_H_ACTIVE: h_stage.active <= wr_val_c;
          CFG_H_TOTAL:  h_stage.total  <= wr_val_c;
          CFG_V_SYNC:   v_stage.sync   <= wr_val_c;
          CFG_V_BACK:   v_stage.back   <= wr_val_c;
          CFG_V_ACTIVE: v_stage.active <= wr_val_c;
          CFG_V_TOTAL:  v_stage.total  <= wr_val_c;
        endcase
      end
      if (wr_ok_c)       cfg_pending <= 1'b1;
      else if (commit_c) cfg_pending <= 1'b0;
    end
  end

  timing_axis #(
    .W        (HCOUNT_WIDTH),
    .SYNC_POL (HSYNC_POL)
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (_reset),
    .halt        (halt_c),
    .zero        (start_c),
    .step        (run_c),
    .total       (h_live.total),
    .dec         (h_dec),
    .pos         (h_pos),
    .sync        (hsync),
    .blank       (hblank),
    .coord       (x),
    .wrap_c      (h_wrap_c),
    .blank_nxt_c (h_blank_nxt_c)
  );

  timing_axis #(
    .W        (VCOUNT_WIDTH),
    .SYNC_POL (VSYNC_POL)
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (_reset),
    .halt        (halt_c),
    .zero        (start_c),
    .step        (run_c && h_wrap_c),
    .total       (v_live.total),
    .dec         (v_dec),
    .pos         (v_pos),
    .sync        (vsync),
    .blank       (vblank),
    .coord       (y),
    .wrap_c      (v_wrap_c),
    .blank_nxt_c (v_blank_nxt_c)
  );

  // Data enable and strobes, aligned with the counters.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= !h_blank_nxt_c && !v_blank_nxt_c;
      line_start  <= start_c || (run_c && h_wrap_c);
      frame_start <= start_c || (run_c && h_wrap_c && v_wrap_c);
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Self-checking bench for display_timing_gen with a behavioural raster model.
module tb_display_timing_gen;

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int HS = 8, HB = 6, HA = 40, HT = 64;
  localparam int VS = 2, VB = 3, VA = 20, VT = 28;
  localparam int FRAME = HT * VT;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;
  localparam int unsigned VECW = 2 * HW + 2 * VW + 8;
  localparam int DEFS [8] = '{HS, HB, HA, HT, VS, VB, VA, VT};

  logic          clk = 1'b0;
  logic          rst_l;
  logic          enable;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [HW-1:0] cfg_data;
  logic          cfg_pending;
  logic [HW-1:0] h_pos;
  logic [VW-1:0] v_pos;
  logic          hsync, vsync, hblank, vblank, de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start, frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state.
  int m_live [8];
  int m_stage [8];
  bit m_pend, m_run;
  int m_h, m_v;
  bit e_hs, e_vs, e_hb, e_vb, e_de, e_ls, e_fs;
  int e_x, e_y;

  always #5 clk = ~clk;

  display_timing_gen #(
    .HCOUNT_WIDTH (HW), .VCOUNT_WIDTH (VW),
    .H_SYNC_DEF (HS), .H_BACK_DEF (HB), .H_ACTIVE_DEF (HA), .H_TOTAL_DEF (HT),
    .V_SYNC_DEF (VS), .V_BACK_DEF (VB), .V_ACTIVE_DEF (VA), .V_TOTAL_DEF (VT),
    .HSYNC_POL (HP), .VSYNC_POL (VP)
  ) dut (
    .clk (clk), ._reset (rst_l), .enable (enable),
    .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_data (cfg_data),
    .cfg_pending (cfg_pending), .h_pos (h_pos), .v_pos (v_pos),
    .hsync (hsync), .vsync (vsync), .hblank (hblank), .vblank (vblank),
    .de (de), .x (x), .y (y),
    .line_start (line_start), .frame_start (frame_start)
  );

  // Advance the model by one clock using the inputs presented at this edge.
  task automatic model_step();
    int htot, vtot, val, lo, hi;
    bit commit, in_h, in_v;
    if (!rst_l) begin
      for (int i = 0; i < 8; i++) begin
        m_live[i] = DEFS[i];
        m_stage[i] = DEFS[i];
      end
      m_pend = 0; m_run = 0; m_h = 0; m_v = 0;
      e_hs = HP; e_vs = VP; e_hb = 1; e_vb = 1; e_de = 0;
      e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
      return;
    end
    htot = m_live[3];
    vtot = m_live[7];
    commit = enable && m_pend && (m_h == htot - 1) && (m_v == vtot - 1);
    if (commit) begin
      m_live = m_stage;
      m_pend = 0;
    end
    if (cfg_we) begin
      val = cfg_addr[2] ? (int'(cfg_data) % (1 << VW)) : int'(cfg_data);
      if (!(cfg_addr[1:0] == 2'd3 && val < 2)) begin
        m_stage[cfg_addr] = val;
        m_pend = 1;
      end
    end
    e_ls = 0;
    e_fs = 0;
    if (!enable) begin
      m_run = 0; m_h = 0; m_v = 0;
      e_hs = !HP; e_vs = !VP; e_hb = 1; e_vb = 1; e_de = 0; e_x = 0; e_y = 0;
      return;
    end
    if (!m_run) begin
      m_run = 1; m_h = 0; m_v = 0; e_ls = 1; e_fs = 1;
    end else begin
      m_h++;
      if (m_h == htot) begin
        m_h = 0;
        e_ls = 1;
        m_v++;
        if (m_v == vtot) begin
          m_v = 0;
          e_fs = 1;
        end
      end
    end
    lo = m_live[0] + m_live[1];
    hi = lo + m_live[2];
    in_h = (m_h >= lo) && (m_h < hi);
    e_hs = (m_h < m_live[0]) ? HP : !HP;
    e_hb = !in_h;
    e_x  = in_h ? m_h - lo : 0;
    lo = m_live[4] + m_live[5];
    hi = lo + m_live[6];
    in_v = (m_v >= lo) && (m_v < hi);
    e_vs = (m_v < m_live[4]) ? VP : !VP;
    e_vb = !in_v;
    e_y  = in_v ? m_v - lo : 0;
    e_de = in_h && in_v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  function automatic logic [VECW-1:0] dut_vec();
    return {h_pos, v_pos, hsync, vsync, hblank, vblank, de, x, y,
            line_start, frame_start, cfg_pending};
  endfunction

  function automatic logic [VECW-1:0] exp_vec();
    return {HW'(m_h), VW'(m_v), e_hs, e_vs, e_hb, e_vb, e_de, HW'(e_x), VW'(e_y),
            e_ls, e_fs, m_pend};
  endfunction

  task automatic write_cfg(input logic [2:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = HW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({h_pos, v_pos, hsync, vsync, hblank, vblank, de, x, y, cfg_pending, line_start, frame_start}
        !== {{HW{1'b0}}, {VW{1'b0}}, HP, VP, 1'b1, 1'b1, 1'b0, {HW{1'b0}}, {VW{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset_values got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b pend=%b",
               h_pos, v_pos, hsync, vsync, hblank, vblank, de, cfg_pending);
    end
  endtask

  task automatic test_defaults();
    int hs_cnt = 0, de_cnt = 0, last_fs, fs_cnt = 0;
    rst_l = 1'b1; enable = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL defaults_first cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
    end
    checks++;
    if (!(line_start === 1'b1 && frame_start === 1'b1 && h_pos === '0 && v_pos === '0)) begin
      errors++;
      $display("FAIL defaults_start got ls=%b fs=%b h=%0d v=%0d want 1 1 0 0",
               line_start, frame_start, h_pos, v_pos);
    end
    last_fs = cyc;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL defaults_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (hsync === HP) hs_cnt++;
      if (de === 1'b1) de_cnt++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        checks++;
        if (cyc - last_fs != FRAME) begin
          errors++;
          $display("FAIL defaults_frame_period got=%0d want=%0d", cyc - last_fs, FRAME);
        end
        last_fs = cyc;
      end
    end
    checks++;
    if (hs_cnt != 2 * VT * HS || de_cnt != 2 * HA * VA || fs_cnt != 2) begin
      errors++;
      $display("FAIL defaults_counts got hs=%0d de=%0d fs=%0d want %0d %0d 2",
               hs_cnt, de_cnt, fs_cnt, 2 * VT * HS, 2 * HA * VA);
    end
  endtask

  task automatic test_reprogram();
    int prev_h, prev_v, de_cnt = 0;
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reprog_seek cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      found = (h_pos == 20 && v_pos == 10);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reprog_seek_timeout got h=%0d v=%0d want h=20 v=10", h_pos, v_pos);
    end
    write_cfg(3'd0, 2); write_cfg(3'd1, 3); write_cfg(3'd2, 8); write_cfg(3'd3, 16);
    write_cfg(3'd4, 1); write_cfg(3'd5, 1); write_cfg(3'd6, 4); write_cfg(3'd7, 8);
    checks++;
    if (cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL reprog_pending got=%b want=1", cfg_pending);
    end
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      prev_h = h_pos; prev_v = v_pos;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reprog_wait cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      found = (frame_start === 1'b1);
    end
    checks++;
    if (!found || prev_h != HT - 1 || prev_v != VT - 1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL reprog_commit got found=%0d prev_h=%0d prev_v=%0d pend=%b want 1 %0d %0d 0",
               found, prev_h, prev_v, cfg_pending, HT - 1, VT - 1);
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reprog_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (de === 1'b1) begin
        de_cnt++;
        checks++;
        if (!(h_pos >= 5 && h_pos <= 12 && v_pos >= 2 && v_pos <= 5)) begin
          errors++;
          $display("FAIL reprog_de_window got h=%0d v=%0d want h 5..12 v 2..5", h_pos, v_pos);
        end
      end
    end
    checks++;
    if (de_cnt != 64 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reprog_de_count got de=%0d fs=%b want 64 1", de_cnt, frame_start);
    end
  endtask

  task automatic test_commit_collision();
    int de_cnt;
    bit found = 0;
    write_cfg(3'd2, 6);
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL collide_seek cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      found = (h_pos == 15 && v_pos == 7);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL collide_seek_timeout got h=%0d v=%0d want 15 7", h_pos, v_pos);
    end
    write_cfg(3'd2, 4);
    checks++;
    if (frame_start !== 1'b1 || cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL collide_pending got fs=%b pend=%b want 1 1", frame_start, cfg_pending);
    end
    for (int f = 0; f < 2; f++) begin
      de_cnt = 0;
      for (int i = 0; i < 128; i++) begin
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL collide_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
        if (de === 1'b1) de_cnt++;
      end
      checks++;
      if (de_cnt != (f == 0 ? 24 : 16) || cfg_pending !== 1'b0) begin
        errors++;
        $display("FAIL collide_frame%0d got de=%0d pend=%b want %0d 0",
                 f, de_cnt, cfg_pending, (f == 0 ? 24 : 16));
      end
    end
  endtask

  task automatic test_bad_total();
    int fs_cnt = 0;
    write_cfg(3'd3, 1);
    write_cfg(3'd7, 0);
    write_cfg(3'd7, 'h400);
    write_cfg(3'd3, 0);
    checks++;
    if (cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL badtotal_pending got=%b want=0", cfg_pending);
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL badtotal_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (frame_start === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL badtotal_frames got=%0d want=2", fs_cnt);
    end
  endtask

  task automatic test_enable_toggle();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL enable_seek cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      found = (h_pos == 7 && v_pos == 3);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL enable_seek_timeout got h=%0d v=%0d want 7 3", h_pos, v_pos);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (h_pos !== '0 || v_pos !== '0 || hsync !== !HP || vsync !== !VP || hblank !== 1'b1 ||
          vblank !== 1'b1 || de !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL enable_idle got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b",
                 h_pos, v_pos, hsync, vsync, hblank, vblank, de, line_start, frame_start);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (line_start !== 1'b1 || frame_start !== 1'b1 || h_pos !== '0 || hsync !== HP) begin
      errors++;
      $display("FAIL enable_restart got ls=%b fs=%b h=%0d hs=%b want 1 1 0 %b",
               line_start, frame_start, h_pos, hsync, HP);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL enable_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midframe();
    int de_cnt = 0;
    write_cfg(3'd3, 30);
    write_cfg(3'd2, 10);
    repeat (20) tick();
    rst_l = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== exp_vec() || cfg_pending !== 1'b0 || h_pos !== '0 || hsync !== HP ||
        hblank !== 1'b1 || de !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values got=%h exp=%h", dut_vec(), exp_vec());
    end
    rst_l = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL midreset_start got fs=%b want 1", frame_start);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (de === 1'b1) de_cnt++;
    end
    checks++;
    if (de_cnt != HA * VA || frame_start !== 1'b1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL midreset_defaults got de=%0d fs=%b pend=%b want %0d 1 0",
               de_cnt, frame_start, cfg_pending, HA * VA);
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] a;
    for (int i = 0; i < 20000; i++) begin
      r = int'($urandom_range(0, 999));
      enable = (r >= 15);
      rst_l  = ($urandom_range(0, 4999) != 0);
      cfg_we = ($urandom_range(0, 99) == 0);
      a = 3'($urandom_range(0, 7));
      cfg_addr = a;
      if (a[1:0] == 2'd3) cfg_data = HW'($urandom_range(0, a[2] ? 12 : 40));
      else                cfg_data = HW'($urandom_range(0, a[2] ? 8 : 24));
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    cfg_we = 1'b0;
    rst_l = 1'b1;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reprogram();
    test_commit_collision();
    test_bad_total();
    test_enable_toggle();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Parametrised, runtime-programmable raster timing generator; successor to the fixed 1024-count scan generator.
- Produces scan counters, sync, blanking, data-enable, active-area coordinates and line/frame strobes.
- Timing comes from defaults or from CPU-written staging registers. Staged values commit atomically at frame wrap.
- Feeds the pixel pipeline and the VGA output pins.

Parameters:
- HCOUNT_WIDTH, 11, width of horizontal counters/timing fields
- VCOUNT_WIDTH, 10, width of vertical counters/timing fields
- H_SYNC_DEF, 128, hsync width in clocks
- H_BACK_DEF, 88, back porch (clocks after sync, before active)
- H_ACTIVE_DEF, 800, active pixels per line
- H_TOTAL_DEF, 1056, clocks per line
- V_SYNC_DEF, 4, vsync lines
- V_BACK_DEF, 23, vertical back porch lines
- V_ACTIVE_DEF, 600, active lines
- V_TOTAL_DEF, 628, lines per frame
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clk  in  1  system clock
- _reset  in  1  synchronous, active-low reset
- enable  in  1  run counters; 0 holds generator idle
- cfg_we  in  1  staging register write strobe
- cfg_addr  in  3  0..3 = H_SYNC,H_BACK,H_ACTIVE,H_TOTAL; 4..7 = V_SYNC,V_BACK,V_ACTIVE,V_TOTAL
- cfg_data  in  HCOUNT_WIDTH  write data (V fields use low VCOUNT_WIDTH bits)
- cfg_pending  out  1  staged values await commit
- h_pos  out  HCOUNT_WIDTH  raw horizontal count
- v_pos  out  VCOUNT_WIDTH  raw vertical count
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- hblank  out  1  outside horizontal active window
- vblank  out  1  outside vertical active window
- de  out  1  ~hblank & ~vblank
- x  out  HCOUNT_WIDTH  h_pos - (hsync_w+hback); 0 when hblank
- y  out  VCOUNT_WIDTH  v_pos - (vsync_w+vback); 0 when vblank
- line_start  out  1  one-clock pulse when h_pos becomes 0
- frame_start  out  1  one-clock pulse when h_pos and v_pos both become 0

Behaviour:
- Register sets:
  - Live set drives all timing. Reset loads the *_DEF values.
  - Staging set is written by cfg_we. Reset also loads the *_DEF values into it.
- Write rules:
  - cfg_we sets cfg_pending = 1.
  - A write of a TOTAL field with value < 2 is ignored; cfg_pending is unchanged.
- Commit:
  - Occurs on the clock where h_pos == h_total-1, v_pos == v_total-1, enable = 1, and cfg_pending = 1.
  - Staging copies to live; cfg_pending clears.
  - A cfg_we in the same clock as a commit: its write lands in staging after the copy, and cfg_pending stays 1.
- Counters (enable = 1):
  - h_pos increments and wraps to 0 after h_total-1.
  - v_pos increments on h wrap, and wraps to 0 after v_total-1.
  - Width overflow is impossible by construction (totals fit the field width).
- enable = 0:
  - h_pos and v_pos clear to 0 next clock. Sync outputs are deasserted; hblank = vblank = 1; de = 0; strobes = 0.
  - The first clock after enable rises gives h_pos = v_pos = 0 with line_start = frame_start = 1.
- Decode:
  - All outputs are registered and aligned with h_pos/v_pos, i.e. decoded from next-count values. Zero skew between counters and decodes.
  - hsync asserted iff h_pos < hsync_w. vsync asserted iff v_pos < vsync_w.
  - hblank = 0 iff hsync_w+hback <= h_pos < hsync_w+hback+hactive. vblank uses the same rule vertically.
- Inconsistent config (sync+back+active > total): windows are truncated at wrap. No error is flagged.
- Reset values:
  - h_pos = v_pos = 0; cfg_pending = 0; x = y = 0; de = 0.
  - hsync = HSYNC_POL, vsync = VSYNC_POL (counter 0 lies in the sync window).
  - hblank = vblank = 1 (with defaults); line_start = frame_start = 0.
- Reset mid-frame: abandons the frame, discards staged values and restores defaults.
- State: two states, IDLE (enable = 0) and RUN. Transitions are IDLE->RUN on enable = 1 and RUN->IDLE on enable = 0, each taking effect next clock.

Decomposition:
- Shared package display_pkg holds:
  - cfg_addr constants CFG_H_SYNC..CFG_V_TOTAL
  - default timing constants
  - a timing-set struct typedef {sync, back, active, total}
- One sub-module, timing_axis, instantiated twice (H and V), parametrised by width. Responsibilities:
  - counter with increment-enable and wrap
  - sync/blank/coordinate decode
  - wrap flag output
- The top level owns the staging/live registers, commit logic, enable FSM and strobes.

Test Plan:
- Reset, enable = 1, defaults -> hsync low for h_pos 0..127, hblank = 0 for h_pos 216..1015, x = 0 at h_pos 216, frame_start every 1056*628 clocks.
- Write H=(2,3,8,16), V=(1,1,4,8) mid-frame -> cfg_pending = 1, old timing continues until frame wrap; next frame line = 16 clocks, de high at h_pos 5..12 on v_pos 2..5, cfg_pending = 0.
- cfg_we coincident with commit clock -> new write retained in staging, cfg_pending stays 1, applied at the following frame.
- Write H_TOTAL = 1 -> ignored, cfg_pending unchanged, timing unaffected.
- Drop enable at h_pos = 7, v_pos = 3, then raise it -> counters at 0 and syncs deasserted while idle; first enabled clock gives line_start = frame_start = 1.
- Assert _reset mid-frame after staging writes -> all outputs at reset values next clock, defaults active, staged data lost.
